column_window_feeder: RTL and testbench
=======================================

Name: column_window_feeder

Overview:
- Upstream stage of the y-moment unit.
- Converts a row-major luma pixel stream into one vertical column of WINDOW_SIZE_Y pixels per accepted pixel. Column order is oldest row to newest row.
- Also supplies the "peek" column: the column that left the moment window WINDOW_SIZE_X valid columns earlier.
- Flags per-column validity and line restarts, so the moment unit accumulates and subtracts without knowing the image geometry.

Parameters:
- LUMA_BITS, 8, bits per pixel.
- WINDOW_SIZE_X, 7, moment window width in valid columns; depth of the peek history.
- WINDOW_SIZE_Y, 5, window height; number of line memories is WINDOW_SIZE_Y-1.
- IMAGE_WIDTH, 640, pixels per image line.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a pixel is presented this cycle and is accepted unconditionally (no backpressure).
- in_pixel  in  LUMA_BITS  pixel value.
- in_frame_start  in  1  qualified by in_valid; pixel is (x=0, row 0) of a new frame.
- in_line_start  in  1  qualified by in_valid; pixel is x=0 of a new line.
- in_col_valid  in  1  column usable by the moment unit (0 = masked column).
- out_strobe  out  1  a column is emitted this cycle.
- out_valid  out  1  emitted column is usable (maps to moment in_valid).
- out_reset  out  1  emitted column is x=0 of a line (maps to moment in_reset).
- out_column  out  LUMA_BITS x WINDOW_SIZE_Y  index 0 = oldest row, index Y-1 = current pixel.
- out_peek_column  out  LUMA_BITS x WINDOW_SIZE_Y  column from WINDOW_SIZE_X valid columns earlier, or all zero.
- out_x  out  $clog2(IMAGE_WIDTH)  x coordinate of the emitted column.

Behaviour:
- Reset state:
  - All outputs 0.
  - x counter 0, row counter 0, peek history count 0.
  - Line-memory contents are not reset.
- Latency: outputs are registered, exactly 1 cycle after the accepting edge.
  - in_valid=0 gives out_strobe=0 next cycle.
  - All other outputs hold their last value while idle.
- Column assembly on an accepted pixel at x:
  - out_column[Y-1] = in_pixel; out_column[k] = line[Y-2-k][x].
  - Then line[0][x] <= in_pixel and line[k][x] <= line[k-1][x] (the line memories form a vertical shift).
- x counter:
  - Increments per accepted pixel.
  - Wraps IMAGE_WIDTH-1 -> 0 and increments the row counter on wrap.
  - in_line_start forces x=0 for that pixel. Row counter +1 unless x was already 0 via wrap (no double count).
  - A premature line start mid-line is legal. The remainder of the old line keeps stale memory data.
- in_frame_start forces x=0 and row counter 0 for that pixel, overriding in_line_start.
- Row counter saturates at WINDOW_SIZE_Y-1.
- out_valid = in_col_valid AND (row counter == WINDOW_SIZE_Y-1).
- out_reset = (x==0) for the emitted column, independent of out_valid.
- Peek history:
  - Ring of WINDOW_SIZE_X columns plus a saturating count.
  - Pushed only for columns with out_valid=1, after peek selection for that column.
  - out_peek_column = oldest ring entry if count == WINDOW_SIZE_X, else all zero.
  - Count cleared at every x=0 column, before that column's push. The x=0 column therefore sees a zero peek.
  - Columns with out_valid=0 present the same peek as the next valid column would and do not advance the ring.
- Simultaneous in_frame_start and in_line_start: treated as a frame start.
- Async reset mid-line: outputs go to 0 immediately, counters cleared. The next pixel is row 0, x=0 regardless of start flags.
- Arithmetic: none beyond counters. Pixel data is passed through unmodified.

Test Plan:
All scenarios use IMAGE_WIDTH=8, WINDOW_SIZE_X=3, WINDOW_SIZE_Y=3, pixel = row*16 + x, and in_col_valid=1 unless stated.
- Reset: assert reset mid-run -> within the same cycle all outputs 0. After release, the first two lines give out_strobe=1, out_valid=0.
- Fill: frame of 3 lines. Row 2, x=4 accepted -> next cycle out_column={0x04,0x14,0x24}, out_valid=1, out_x=4, out_reset=0.
- Peek and line start:
  - Row 2, x=0..2 -> peek all zero; out_reset=1 only at x=0.
  - x=3 -> peek {0x00,0x10,0x20}.
  - x=7 -> peek {0x04,0x14,0x24}.
- Masked column: row 2, in_col_valid=0 at x=2 -> x=2 out_valid=0.
  - x=3 -> peek zero.
  - x=4 -> peek {0x00,0x10,0x20}.
  - x=5 -> peek {0x01,0x11,0x21}.
- Stall: in_valid=0 for 5 cycles after row 2, x=3 -> out_strobe=0 and outputs held. Resume -> x=4 column and peek identical to the unstalled run.
- Early line start: in_line_start at row 2, x=5 -> emitted out_x=0, out_reset=1, peek zero, row counter stays saturated, out_valid=1.

Source files
------------

// File: rtl/column_window_feeder.sv
// Turns a row-major luma stream into one vertical column per accepted pixel, plus the
// "peek" column that left the moment window WINDOW_SIZE_X valid columns earlier.
module column_window_feeder #(
    parameter int unsigned LUMA_BITS     = 8,
    parameter int unsigned WINDOW_SIZE_X = 7,
    parameter int unsigned WINDOW_SIZE_Y = 5,
    parameter int unsigned IMAGE_WIDTH   = 640
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    input  logic [LUMA_BITS-1:0]                      in_pixel,
    input  logic                                      in_frame_start,
    input  logic                                      in_line_start,
    input  logic                                      in_col_valid,
    output logic                                      out_strobe,
    output logic                                      out_valid,
    output logic                                      out_reset,
    output logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]   out_column,
    output logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]   out_peek_column,
    output logic [$clog2(IMAGE_WIDTH)-1:0]            out_x
);

    localparam int unsigned XW = $clog2(IMAGE_WIDTH);
    localparam int unsigned RW = (WINDOW_SIZE_Y > 2) ? $clog2(WINDOW_SIZE_Y) : 1;
    localparam int unsigned CW = $clog2(WINDOW_SIZE_X + 1);
    localparam int unsigned PW = (WINDOW_SIZE_X > 1) ? $clog2(WINDOW_SIZE_X) : 1;

    localparam logic [XW-1:0] X_MAX   = XW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(WINDOW_SIZE_Y - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WINDOW_SIZE_X);
    localparam logic [PW-1:0] WP_MAX  = PW'(WINDOW_SIZE_X - 1);

    typedef logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0] column_t;

    // Line memories: r_line[0] holds the row just above the current one.
    logic [LUMA_BITS-1:0] r_line [WINDOW_SIZE_Y-1][IMAGE_WIDTH];
    column_t              r_ring [WINDOW_SIZE_X];

    logic [XW-1:0] r_x;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_wp;

    logic [XW-1:0] w_x;
    logic [XW-1:0] w_x_nxt;
    logic [RW-1:0] w_row;
    logic [RW-1:0] w_row_nxt;
    logic          w_wrap;
    logic          w_col_ok;
    logic [CW-1:0] w_cnt;
    column_t       w_column;
    column_t       w_peek;

    // Resolve this pixel's position; r_x == 0 means the wrap already bumped the row.
    always_comb begin
        w_x   = r_x;
        w_row = r_row;
        if (in_frame_start) begin
            w_x   = '0;
            w_row = '0;
        end else if (in_line_start) begin
            w_x = '0;
            if (r_x != '0 && r_row != ROW_MAX) begin
                w_row = r_row + RW'(1);
            end
        end
        w_wrap    = (w_x == X_MAX);
        w_x_nxt   = w_wrap ? '0 : w_x + XW'(1);
        w_row_nxt = (w_wrap && w_row != ROW_MAX) ? w_row + RW'(1) : w_row;
    end

    always_comb begin
        w_column = '0;
        for (int unsigned k = 0; k < WINDOW_SIZE_Y - 1; k++) begin
            w_column[k] = r_line[WINDOW_SIZE_Y-2-k][w_x];
        end
        w_column[WINDOW_SIZE_Y-1] = in_pixel;
        w_col_ok = in_col_valid && (w_row == ROW_MAX);
        w_cnt    = (w_x == '0) ? '0 : r_cnt;
        w_peek   = (w_cnt == CNT_MAX) ? r_ring[r_wp] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x             <= '0;
            r_row           <= '0;
            r_cnt           <= '0;
            r_wp            <= '0;
            out_strobe      <= 1'b0;
            out_valid       <= 1'b0;
            out_reset       <= 1'b0;
            out_column      <= '0;
            out_peek_column <= '0;
            out_x           <= '0;
        end else begin
            out_strobe <= in_valid;
            if (in_valid) begin
                r_x             <= w_x_nxt;
                r_row           <= w_row_nxt;
                out_valid       <= w_col_ok;
                out_reset       <= (w_x == '0);
                out_column      <= w_column;
                out_peek_column <= w_peek;
                out_x           <= w_x;
                if (w_col_ok) begin
                    r_wp  <= (r_wp == WP_MAX) ? '0 : r_wp + PW'(1);
                    r_cnt <= (w_cnt == CNT_MAX) ? w_cnt : w_cnt + CW'(1);
                end else begin
                    r_cnt <= w_cnt;
                end
            end
        end
    end

    // Storage only; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_line[0][w_x] <= in_pixel;
            for (int unsigned k = 1; k < WINDOW_SIZE_Y - 1; k++) begin
                r_line[k][w_x] <= r_line[k-1][w_x];
            end
            if (w_col_ok) begin
                r_ring[r_wp] <= w_column;
            end
        end
    end

endmodule

// File: tb/tb_column_window_feeder.sv
// Directed plus randomized bench for column_window_feeder against a queue-based model.
module tb_column_window_feeder;

    localparam int LB = 8;
    localparam int WX = 3;
    localparam int WY = 3;
    localparam int IW = 8;
    localparam int XW = $clog2(IW);

    typedef logic [WY-1:0][LB-1:0] col_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [LB-1:0] in_pixel;
    logic          in_frame_start;
    logic          in_line_start;
    logic          in_col_valid;
    logic          out_strobe;
    logic          out_valid;
    logic          out_reset;
    col_t          out_column;
    col_t          out_peek_column;
    logic [XW-1:0] out_x;

    column_window_feeder #(
        .LUMA_BITS    (LB),
        .WINDOW_SIZE_X(WX),
        .WINDOW_SIZE_Y(WY),
        .IMAGE_WIDTH  (IW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_pixel       (in_pixel),
        .in_frame_start (in_frame_start),
        .in_line_start  (in_line_start),
        .in_col_valid   (in_col_valid),
        .out_strobe     (out_strobe),
        .out_valid      (out_valid),
        .out_reset      (out_reset),
        .out_column     (out_column),
        .out_peek_column(out_peek_column),
        .out_x          (out_x)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: next x, row, per-x pixel history (newest last), valid columns since line start.
    int        m_nx;
    int        m_row;
    logic [LB-1:0] hmem [IW][WY-1];
    int        hcnt [IW];
    col_t      peekq[$];
    logic      e_valid;
    logic      e_reset;
    int        e_x;
    col_t      e_col;
    col_t      e_peek;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_col(input string tag, input col_t obs, input col_t exp);
        for (int k = 0; k < WY; k++) begin
            if (!$isunknown(exp[k])) chk($sformatf("%s[%0d]", tag, k), 64'(obs[k]), 64'(exp[k]));
        end
    endtask

    task automatic model_reset();
        m_nx    = 0;
        m_row   = 0;
        peekq.delete();
        e_valid = 1'b0;
        e_reset = 1'b0;
        e_x     = 0;
        e_col   = '0;
        e_peek  = '0;
    endtask

    task automatic model_accept(input logic [LB-1:0] pix, input bit fs, input bit ls, input bit cv);
        int   x;
        col_t col;
        if (fs) begin
            x     = 0;
            m_row = 0;
        end else if (ls) begin
            if (m_nx != 0 && m_row < WY - 1) m_row++;
            x = 0;
        end else begin
            x = m_nx;
        end
        col[WY-1] = pix;
        for (int j = 0; j < WY - 1; j++) begin
            // j = 0 is the most recent row above
            col[WY-2-j] = (j < hcnt[x]) ? hmem[x][hcnt[x]-1-j] : 'x;
        end
        if (hcnt[x] == WY - 1) begin
            for (int j = 0; j < WY - 2; j++) hmem[x][j] = hmem[x][j+1];
            hmem[x][WY-2] = pix;
        end else begin
            hmem[x][hcnt[x]] = pix;
            hcnt[x]++;
        end
        e_valid = cv && (m_row == WY - 1);
        if (x == 0) peekq.delete();
        e_peek = (peekq.size() == WX) ? peekq[0] : '0;
        if (e_valid) begin
            peekq.push_back(col);
            if (peekq.size() > WX) void'(peekq.pop_front());
        end
        e_reset = (x == 0);
        e_x     = x;
        e_col   = col;
        m_nx    = x + 1;
        if (m_nx == IW) begin
            m_nx = 0;
            if (m_row < WY - 1) m_row++;
        end
    endtask

    task automatic step(input bit v, input logic [LB-1:0] pix, input bit fs, input bit ls,
                        input bit cv);
        @(negedge clk);
        in_valid       = v;
        in_pixel       = pix;
        in_frame_start = fs;
        in_line_start  = ls;
        in_col_valid   = cv;
        @(posedge clk);
        #1;
        if (v) model_accept(pix, fs, ls, cv);
        chk("strobe", 64'(out_strobe), 64'(v));
        chk("valid", 64'(out_valid), 64'(e_valid));
        chk("reset", 64'(out_reset), 64'(e_reset));
        chk("x", 64'(out_x), 64'(e_x));
        chk_col("column", out_column, e_col);
        chk_col("peek", out_peek_column, e_peek);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_strobe"}, 64'(out_strobe), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_reset"}, 64'(out_reset), 64'd0);
        chk({tag, "_x"}, 64'(out_x), 64'd0);
        chk({tag, "_column"}, 64'(out_column), 64'd0);
        chk({tag, "_peek"}, 64'(out_peek_column), 64'd0);
    endtask

    function automatic logic [LB-1:0] pv(input int r, input int x);
        return LB'(r * 16 + x);
    endfunction

    task automatic full_line(input int r, input bit fs);
        for (int x = 0; x < IW; x++) step(1'b1, pv(r, x), fs && x == 0, x == 0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < IW; i++) hcnt[i] = 0;
        model_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        in_frame_start = 1'b0;
        in_line_start = 1'b0;
        in_col_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // Fill and peek progression
        for (int r = 0; r < 3; r++) begin
            for (int x = 0; x < IW; x++) begin
                step(1'b1, pv(r, x), r == 0 && x == 0, x == 0, 1'b1);
                if (r < 2) chk("warmup_valid", 64'(out_valid), 64'd0);
                if (r == 2 && x == 4) begin
                    chk("fill_col", 64'(out_column), 64'h241404);
                    chk("fill_valid", 64'(out_valid), 64'd1);
                end
                if (r == 2 && x <= 2) chk("early_peek", 64'(out_peek_column), 64'd0);
                if (r == 2 && x == 3) chk("peek_x3", 64'(out_peek_column), 64'h201000);
                if (r == 2 && x == 7) chk("peek_x7", 64'(out_peek_column), 64'h241404);
            end
        end

        // Masked column at x=2
        full_line(0, 1'b1);
        full_line(1, 1'b0);
        for (int x = 0; x < IW; x++) begin
            step(1'b1, pv(2, x), 1'b0, x == 0, x != 2);
            if (x == 2) chk("mask_valid", 64'(out_valid), 64'd0);
            if (x == 3) chk("mask_peek3", 64'(out_peek_column), 64'd0);
            if (x == 4) chk("mask_peek4", 64'(out_peek_column), 64'h201000);
            if (x == 5) chk("mask_peek5", 64'(out_peek_column), 64'h211101);
        end

        // Stall after row 2, x=3
        full_line(0, 1'b1);
        full_line(1, 1'b0);
        for (int x = 0; x < 4; x++) step(1'b1, pv(2, x), 1'b0, x == 0, 1'b1);
        repeat (5) step(1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
        for (int x = 4; x < IW; x++) begin
            step(1'b1, pv(2, x), 1'b0, 1'b0, 1'b1);
            if (x == 4) chk("stall_peek4", 64'(out_peek_column), 64'h211101);
        end

        // Premature line start at row 2, x=5
        full_line(0, 1'b1);
        full_line(1, 1'b0);
        for (int x = 0; x < 5; x++) step(1'b1, pv(2, x), 1'b0, x == 0, 1'b1);
        step(1'b1, pv(2, 5), 1'b0, 1'b1, 1'b1);
        chk("els_x", 64'(out_x), 64'd0);
        chk("els_reset", 64'(out_reset), 64'd1);
        chk("els_peek", 64'(out_peek_column), 64'd0);
        chk("els_valid", 64'(out_valid), 64'd1);
        for (int x = 1; x < IW; x++) step(1'b1, pv(3, x), 1'b0, 1'b0, 1'b1);

        // Randomized frames: gaps, masked columns, stray line starts, simultaneous flags
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < 5 * IW; p++) begin
                if ($urandom_range(3) == 0) step(1'b0, LB'($urandom), 1'b0, 1'b0, 1'b0);
                step(1'b1, LB'($urandom), p == 0, (p == 0 && f[0]) || $urandom_range(15) == 0,
                     $urandom_range(4) != 0);
            end
        end

        // Asynchronous reset mid-line
        full_line(0, 1'b1);
        for (int x = 0; x < 3; x++) step(1'b1, pv(1, x), 1'b0, x == 0, 1'b1);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int x = 0; x < IW; x++) begin
                step(1'b1, pv(r, x), 1'b0, x == 0, 1'b1);
                if (r < 2) chk("post_rst_valid", 64'(out_valid), 64'd0);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
